// File: rtl/pid_pkg.sv
// Shared types, term indices and width/limit helpers for the multi-channel PID core.
package pid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MUL,
      ST_ACC,
      ST_WRITE,
      ST_NEXT
   } pid_state_t;

   // Term order matches the coefficient packing {a1,a0,b2,b1,b0}, b0 in the LSBs.
   localparam logic [2:0] TERM_B0 = 3'd0;
   localparam logic [2:0] TERM_B1 = 3'd1;
   localparam logic [2:0] TERM_B2 = 3'd2;
   localparam logic [2:0] TERM_A0 = 3'd3;
   localparam logic [2:0] TERM_A1 = 3'd4;
   localparam int         NUM_TERMS = 5;

   // Stored y: sign + (ADC+1) integer bits + FRAC fraction bits.
   function automatic int y_width(input int adc_w, input int frac_w);
      return adc_w + frac_w + 2;
   endfunction

   // One iteration per multiplier bit plus the done register.
   function automatic int mul_latency(input int adc_w, input int frac_w);
      return y_width(adc_w, frac_w) + 1;
   endfunction

   // Each product is below 2^(REG+ADC) in magnitude; five of them plus sign.
   function automatic int acc_width(input int reg_w, input int adc_w);
      return reg_w + adc_w + 4;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int out_limit(input int adc_w);
      return (1 << adc_w) - 1;
   endfunction

endpackage

// File: rtl/pid_seq_mul.sv
// Signed sequential shift-add multiplier; start pulse to done pulse takes B_W+1 cycles.
module pid_seq_mul #(
   parameter int A_W = 32,
   parameter int B_W = 34
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [A_W-1:0]     a_i,
   input  logic [B_W-1:0]     b_i,
   output logic               done_o,
   output logic [A_W+B_W-1:0] prod_o
);

   localparam int             P_W  = A_W + B_W;
   localparam int             CW   = $clog2(B_W) + 1;
   localparam logic [CW-1:0]  LAST = CW'(B_W - 1);

   logic [P_W-1:0] mcand_q;
   logic [P_W-1:0] prod_q;
   logic [B_W-1:0] mplier_q;
   logic [CW-1:0]  cnt_q;
   logic           run_q;
   logic           done_q;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            mcand_q  <= {{B_W{a_i[A_W-1]}}, a_i};
            mplier_q <= b_i;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
         end else if (run_q) begin
            // The multiplier MSB carries negative weight in two's complement.
            if (mplier_q[0]) begin
               prod_q <= (cnt_q == LAST) ? prod_q - mcand_q : prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign prod_o = prod_q;

endmodule

// File: rtl/pid_multi_core.sv
// Time-multiplexed multi-channel PID (direct-form IIR) sharing one sequential multiplier.
// Optional macro PID_ANTIWINDUP_EN: store the clamped output as y history instead of the wide limit.
module pid_multi_core
   import pid_pkg::*;
#(
   parameter int CHANNELS      = 2,
   parameter int ADC_BITWIDTH  = 8,
   parameter int REG_BITWIDTH  = 32,
   parameter int FRAC_BITWIDTH = 24
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clk_en_pid_i,
   input  logic [CHANNELS-1:0]                 ch_en_i,
   input  logic [CHANNELS*ADC_BITWIDTH-1:0]    adc_value_i,
   input  logic [CHANNELS*ADC_BITWIDTH-1:0]    set_value_i,
   input  logic [CHANNELS*5*REG_BITWIDTH-1:0]  coeff_i,
   output logic [CHANNELS*(ADC_BITWIDTH+1)-1:0] out_val_o,
   output logic                                busy_o,
   output logic                                done_o,
   output logic                                overrun_o
);

   localparam int E_W   = ADC_BITWIDTH + 1;
   localparam int Y_W   = y_width(ADC_BITWIDTH, FRAC_BITWIDTH);
   localparam int ACC_W = acc_width(REG_BITWIDTH, ADC_BITWIDTH);
   localparam int P_W   = REG_BITWIDTH + Y_W;
   localparam int CH_W  = idx_width(CHANNELS);

   localparam logic signed [ACC_W-1:0] ONE      = 1;
   localparam logic signed [ACC_W-1:0] O_LIM    = ACC_W'(out_limit(ADC_BITWIDTH));
   localparam logic signed [ACC_W-1:0] O_NEG    = -O_LIM;
   localparam logic signed [ACC_W-1:0] O_LIM_FX = O_LIM <<< FRAC_BITWIDTH;
   localparam logic signed [ACC_W-1:0] O_NEG_FX = O_NEG <<< FRAC_BITWIDTH;
   localparam logic signed [ACC_W-1:0] Y_LIM    = (ONE <<< (ADC_BITWIDTH + 1 + FRAC_BITWIDTH)) - ONE;
   localparam logic signed [ACC_W-1:0] Y_NEG    = -Y_LIM;

   pid_state_t state_q, state_d;

   logic [CHANNELS-1:0]     en_q;
   logic [CH_W-1:0]         ch_q;
   logic [2:0]              term_q;
   logic [REG_BITWIDTH-1:0] coef_q [NUM_TERMS];
   logic [E_W-1:0]          e0_w, e1_w, e2_w;
   logic [Y_W-1:0]          y1_w, y2_w;
   logic signed [ACC_W-1:0] acc_q;
   logic                    done_q, ovr_q;

   logic [E_W-1:0] e1_q  [CHANNELS];
   logic [E_W-1:0] e2_q  [CHANNELS];
   logic [Y_W-1:0] y1_q  [CHANNELS];
   logic [Y_W-1:0] y2_q  [CHANNELS];
   logic [E_W-1:0] out_q [CHANNELS];

   logic                    mul_start, mul_done;
   logic [REG_BITWIDTH-1:0] mul_a;
   logic [Y_W-1:0]          mul_b;
   logic [P_W-1:0]          mul_prod;
   logic signed [P_W-1:0]   prod_sh;
   logic signed [ACC_W-1:0] term_val, acc_int;
   logic                    y_term;
   logic [E_W-1:0]          err, out_new;
   logic [Y_W-1:0]          y_new;
   logic [CH_W-1:0]         first_ch, nxt_ch;
   logic                    nxt_found;

   pid_seq_mul #(.A_W(REG_BITWIDTH), .B_W(Y_W)) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (mul_start),
      .a_i     (mul_a),
      .b_i     (mul_b),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      first_ch = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (ch_en_i[i]) first_ch = CH_W'(i);
      end
      nxt_found = 1'b0;
      nxt_ch    = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (en_q[i] && (i > int'(ch_q))) begin
            nxt_found = 1'b1;
            nxt_ch    = CH_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (clk_en_pid_i && (|ch_en_i)) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_MUL;
         ST_MUL:   state_d = ST_ACC;
         ST_ACC:   if (mul_done) state_d = (term_q == TERM_A1) ? ST_WRITE : ST_MUL;
         ST_WRITE: state_d = ST_NEXT;
         ST_NEXT:  state_d = nxt_found ? ST_LOAD : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mul_start = (state_q == ST_MUL);
      y_term    = (term_q == TERM_A0) || (term_q == TERM_A1);
      case (term_q)
         TERM_B0: begin mul_a = coef_q[0]; mul_b = {{(Y_W-E_W){e0_w[E_W-1]}}, e0_w}; end
         TERM_B1: begin mul_a = coef_q[1]; mul_b = {{(Y_W-E_W){e1_w[E_W-1]}}, e1_w}; end
         TERM_B2: begin mul_a = coef_q[2]; mul_b = {{(Y_W-E_W){e2_w[E_W-1]}}, e2_w}; end
         TERM_A0: begin mul_a = coef_q[3]; mul_b = y1_w; end
         default: begin mul_a = coef_q[4]; mul_b = y2_w; end
      endcase
      // coeff*y carries 2*FRAC fraction bits; drop FRAC of them, rounding toward -inf.
      prod_sh  = $signed(mul_prod) >>> FRAC_BITWIDTH;
      term_val = y_term ? prod_sh[ACC_W-1:0] : mul_prod[ACC_W-1:0];
      err      = {1'b0, set_value_i[int'(ch_q)*ADC_BITWIDTH +: ADC_BITWIDTH]}
               - {1'b0, adc_value_i[int'(ch_q)*ADC_BITWIDTH +: ADC_BITWIDTH]};
      acc_int  = acc_q >>> FRAC_BITWIDTH;
      if (acc_int > O_LIM)      out_new = O_LIM[E_W-1:0];
      else if (acc_int < O_NEG) out_new = O_NEG[E_W-1:0];
      else                      out_new = acc_int[E_W-1:0];
`ifdef PID_ANTIWINDUP_EN
      if (acc_int > O_LIM)      y_new = O_LIM_FX[Y_W-1:0];
      else if (acc_int < O_NEG) y_new = O_NEG_FX[Y_W-1:0];
      else                      y_new = acc_q[Y_W-1:0];
`else
      if (acc_q > Y_LIM)        y_new = Y_LIM[Y_W-1:0];
      else if (acc_q < Y_NEG)   y_new = Y_NEG[Y_W-1:0];
      else                      y_new = acc_q[Y_W-1:0];
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q   <= '0;
         ch_q   <= '0;
         term_q <= TERM_B0;
         acc_q  <= '0;
         e0_w   <= '0;
         e1_w   <= '0;
         e2_w   <= '0;
         y1_w   <= '0;
         y2_w   <= '0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
         for (int k = 0; k < NUM_TERMS; k++) coef_q[k] <= '0;
         // NOTE: history arrays are reset explicitly; stale e/y would leak into
         // the first pass after reset, so this storage cannot be left to power-up.
         for (int c = 0; c < CHANNELS; c++) begin
            e1_q[c]  <= '0;
            e2_q[c]  <= '0;
            y1_q[c]  <= '0;
            y2_q[c]  <= '0;
            out_q[c] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         ovr_q  <= clk_en_pid_i && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (clk_en_pid_i) begin
                  en_q   <= ch_en_i;
                  ch_q   <= first_ch;
                  done_q <= ~(|ch_en_i);
               end
            end
            ST_LOAD: begin
               for (int k = 0; k < NUM_TERMS; k++) begin
                  coef_q[k] <= coeff_i[(int'(ch_q)*NUM_TERMS + k)*REG_BITWIDTH +: REG_BITWIDTH];
               end
               e0_w       <= err;
               e1_w       <= e1_q[ch_q];
               e2_w       <= e2_q[ch_q];
               y1_w       <= y1_q[ch_q];
               y2_w       <= y2_q[ch_q];
               e1_q[ch_q] <= err;
               e2_q[ch_q] <= e1_q[ch_q];
               acc_q      <= '0;
               term_q     <= TERM_B0;
            end
            ST_ACC: begin
               if (mul_done) begin
                  acc_q  <= y_term ? acc_q - term_val : acc_q + term_val;
                  term_q <= term_q + 3'd1;
               end
            end
            ST_WRITE: begin
               out_q[ch_q] <= out_new;
               y1_q[ch_q]  <= y_new;
               y2_q[ch_q]  <= y1_q[ch_q];
            end
            ST_NEXT: begin
               if (nxt_found) ch_q   <= nxt_ch;
               else           done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign out_val_o[g*E_W +: E_W] = out_q[g];
   end

   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = done_q;
   assign overrun_o = ovr_q;

endmodule

// File: tb/tb_pid_multi_core.sv
// Self-checking bench for pid_multi_core: table vectors plus multi-pass sequences, scoreboarded on done_o.
module tb_pid_multi_core;

   localparam int CH       = 2;
   localparam int ADC      = 8;
   localparam int REG      = 32;
   localparam int FRAC     = 24;
   localparam int E_W      = ADC + 1;
   localparam int MUL_LAT  = ADC + FRAC + 3;
   localparam int CH_LAT   = 2 + 5 * (MUL_LAT + 1) + 1;
   localparam int PASS_LAT = 2 * CH_LAT;

   localparam logic [31:0] C_ONE      = 32'h0100_0000;
   localparam logic [31:0] C_NEG_ONE  = 32'hFF00_0000;
   localparam logic [31:0] C_HALF     = 32'h0080_0000;
   localparam logic [31:0] C_NEG_HALF = 32'hFF80_0000;
   localparam logic [31:0] C_QUARTER  = 32'h0040_0000;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    clk_en;
   logic [CH-1:0]           ch_en;
   logic [CH*ADC-1:0]       adc_val;
   logic [CH*ADC-1:0]       set_val;
   logic [CH*5*REG-1:0]     coeff;
   logic [CH*E_W-1:0]       out_val;
   logic                    busy, done, overrun;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]  set0, adc0, set1, adc1;
      logic [31:0] k0, k1;
      int          exp0, exp1;
   } vec_t;

   typedef struct {
      int exp0;
      int exp1;
      int lat;
   } sb_t;

   vec_t vecs [6];
   sb_t  sb_q [$];

   pid_multi_core #(
      .CHANNELS(CH), .ADC_BITWIDTH(ADC), .REG_BITWIDTH(REG), .FRAC_BITWIDTH(FRAC)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clk_en_pid_i (clk_en),
      .ch_en_i      (ch_en),
      .adc_value_i  (adc_val),
      .set_value_i  (set_val),
      .coeff_i      (coeff),
      .out_val_o    (out_val),
      .busy_o       (busy),
      .done_o       (done),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int out_ch(input int i);
      logic [E_W-1:0] v;
      v = out_val[i*E_W +: E_W];
      return int'($signed(v));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_coef(input int ch, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] a0, input logic [31:0] a1);
      coeff[(ch*5+0)*REG +: REG] = b0;
      coeff[(ch*5+1)*REG +: REG] = b1;
      coeff[(ch*5+2)*REG +: REG] = b2;
      coeff[(ch*5+3)*REG +: REG] = a0;
      coeff[(ch*5+4)*REG +: REG] = a1;
   endtask

   task automatic set_in(input int ch, input logic [7:0] sp, input logic [7:0] adc);
      set_val[ch*ADC +: ADC] = sp;
      adc_val[ch*ADC +: ADC] = adc;
   endtask

   // ovr_at >= 0 fires a second strobe in that cycle of the pass (counted from LOAD).
   task automatic run_pass(input logic [1:0] en, input int exp0, input int exp1,
                           input int lat, input int ovr_at);
      sb_t s;
      int  c;
      s.exp0 = exp0;
      s.exp1 = exp1;
      s.lat  = lat;
      sb_q.push_back(s);
      ch_en  = en;
      clk_en = 1'b1;
      tick();
      clk_en = 1'b0;
      if (en != 2'b00) check("busy_after_strobe", busy, 1);
      c = 0;
      while (!done && c < 1000) begin
         if (c == ovr_at) clk_en = 1'b1;
         tick();
         c++;
         if (c == ovr_at + 1) begin
            clk_en = 1'b0;
            check("overrun_pulse", overrun, 1);
         end
      end
      check("done_seen", done, 1);
      s = sb_q.pop_front();
      check("latency", c, s.lat);
      check("out_ch0", out_ch(0), s.exp0);
      check("out_ch1", out_ch(1), s.exp1);
      check("busy_at_done", busy, 0);
      check("overrun_at_done", overrun, 0);
      tick();
      check("done_one_cycle", done, 0);
      check("no_restart", busy, 0);
   endtask

   initial begin
      int dcount;
      int aw_last;

      rst     = 1'b1;
      clk_en  = 1'b0;
      ch_en   = '0;
      adc_val = '0;
      set_val = '0;
      coeff   = '0;

      vecs[0] = '{set0: 8'd100, adc0: 8'd40,  set1: 8'd0,   adc1: 8'd0,
                  k0: C_ONE,         k1: C_ONE,         exp0: 60,   exp1: 0};
      vecs[1] = '{set0: 8'd0,   adc0: 8'd200, set1: 8'd255, adc1: 8'd0,
                  k0: 32'h0200_0000, k1: 32'h0400_0000, exp0: -255, exp1: 255};
      vecs[2] = '{set0: 8'd0,   adc0: 8'd3,   set1: 8'd3,   adc1: 8'd0,
                  k0: C_HALF,        k1: C_HALF,        exp0: -2,   exp1: 1};
      vecs[3] = '{set0: 8'd10,  adc0: 8'd0,   set1: 8'd255, adc1: 8'd0,
                  k0: C_NEG_ONE,     k1: C_ONE,         exp0: -10,  exp1: 255};
      vecs[4] = '{set0: 8'd0,   adc0: 8'd255, set1: 8'd255, adc1: 8'd0,
                  k0: C_ONE,         k1: 32'h0100_0001, exp0: -255, exp1: 255};
      vecs[5] = '{set0: 8'd255, adc0: 8'd0,   set1: 8'd255, adc1: 8'd0,
                  k0: 32'h7FFF_FFFF, k1: 32'h8000_0000, exp0: 255,  exp1: -255};

      tick();
      tick();
      rst = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_overrun", overrun, 0);
      check("reset_out0", out_ch(0), 0);
      check("reset_out1", out_ch(1), 0);

      // Single-pass vectors from a cleared history: out = floor(b0*e) clamped.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         set_coef(0, vecs[i].k0, '0, '0, '0, '0);
         set_coef(1, vecs[i].k1, '0, '0, '0, '0);
         set_in(0, vecs[i].set0, vecs[i].adc0);
         set_in(1, vecs[i].set1, vecs[i].adc1);
         run_pass(2'b11, vecs[i].exp0, vecs[i].exp1, PASS_LAT, -1);
      end

      // Integrator, constant error of 10.
      do_reset();
      set_coef(0, C_ONE, '0, '0, C_NEG_ONE, '0);
      set_coef(1, '0, '0, '0, '0, '0);
      set_in(0, 8'd10, 8'd0);
      set_in(1, 8'd0, 8'd0);
      for (int k = 1; k <= 4; k++) run_pass(2'b11, 10 * k, 0, PASS_LAT, -1);

      // Integrator wind-up then reversal.
      do_reset();
      set_in(0, 8'd100, 8'd0);
      run_pass(2'b11, 100, 0, PASS_LAT, -1);
      run_pass(2'b11, 200, 0, PASS_LAT, -1);
      run_pass(2'b11, 255, 0, PASS_LAT, -1);
      set_in(0, 8'd0, 8'd50);
`ifdef PID_ANTIWINDUP_EN
      aw_last = 205;
`else
      aw_last = 250;
`endif
      run_pass(2'b11, aw_last, 0, PASS_LAT, -1);

      // e-history taps on ch0 (b1=0.5, b2=0.25), y[n-2] tap on ch1 (a1=-0.5).
      do_reset();
      set_coef(0, C_ONE, C_HALF, C_QUARTER, '0, '0);
      set_coef(1, C_ONE, '0, '0, '0, C_NEG_HALF);
      set_in(0, 8'd40, 8'd0);
      set_in(1, 8'd64, 8'd0);
      run_pass(2'b11, 40, 64, PASS_LAT, -1);
      run_pass(2'b11, 60, 64, PASS_LAT, -1);
      run_pass(2'b11, 70, 96, PASS_LAT, -1);

      // Channel masks: disabled channels keep output and history.
      do_reset();
      set_coef(0, C_ONE, '0, '0, C_NEG_ONE, '0);
      set_coef(1, C_ONE, '0, '0, '0, '0);
      set_in(0, 8'd10, 8'd0);
      set_in(1, 8'd5, 8'd0);
      run_pass(2'b11, 10, 5, PASS_LAT, -1);
      set_in(1, 8'd7, 8'd0);
      run_pass(2'b10, 10, 7, CH_LAT, -1);
      run_pass(2'b11, 20, 7, PASS_LAT, -1);
      set_in(1, 8'd9, 8'd0);
      run_pass(2'b01, 30, 7, CH_LAT, -1);
      run_pass(2'b00, 30, 7, 0, -1);

      // Overrun mid-pass and coincident with the last channel's WRITE.
      do_reset();
      set_coef(0, C_ONE, '0, '0, '0, '0);
      set_coef(1, '0, '0, '0, '0, '0);
      set_in(0, 8'd100, 8'd40);
      set_in(1, 8'd0, 8'd0);
      run_pass(2'b11, 60, 0, PASS_LAT, 100);
      run_pass(2'b11, 60, 0, PASS_LAT, CH_LAT + 2 + 5 * (MUL_LAT + 1) - 1);

      // Reset during the first MUL of ch1 aborts the pass and clears history.
      do_reset();
      set_coef(0, C_ONE, '0, '0, C_NEG_ONE, '0);
      set_coef(1, C_ONE, '0, '0, '0, '0);
      set_in(0, 8'd10, 8'd0);
      set_in(1, 8'd5, 8'd0);
      run_pass(2'b11, 10, 5, PASS_LAT, -1);
      sb_q.push_back('{exp0: 20, exp1: 5, lat: PASS_LAT});
      ch_en  = 2'b11;
      clk_en = 1'b1;
      tick();
      clk_en = 1'b0;
      for (int c = 0; c < CH_LAT + 1; c++) tick();
      check("pre_abort_out0", out_ch(0), 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb_q.delete();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_overrun", overrun, 0);
      check("abort_out0", out_ch(0), 0);
      check("abort_out1", out_ch(1), 0);
      dcount = 0;
      for (int c = 0; c < PASS_LAT + 40; c++) begin
         tick();
         if (done) dcount++;
      end
      check("no_done_after_abort", dcount, 0);
      run_pass(2'b11, 10, 5, PASS_LAT, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
